// File: rtl/song_sequencer_pkg.sv
// Shared types and constants for the song sequencer: FSM state encoding,
// default song count, song-index width and the song-advance helper.
package song_sequencer_pkg;

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        PAUSED  = 2'd1,
        PLAYING = 2'd2,
        GAP     = 2'd3
    } seq_state_t;

    localparam int NUM_SONGS_DEFAULT = 4;
    localparam int SONG_W            = 2;

    // Wraps from the last song back to song 0.
    function automatic logic [SONG_W-1:0] advance_song(input logic [SONG_W-1:0] cur,
                                                       input int num_songs);
        return (int'(cur) == num_songs - 1) ? '0 : cur + SONG_W'(1);
    endfunction

endpackage

// File: rtl/song_gap_timer.sv
// Silent-gap counter: cleared by load, counts while enabled, and saturates
// at GAP_CYCLES-1, where expired is raised.
module song_gap_timer #(
    parameter int GAP_CYCLES = 48000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(GAP_CYCLES + 1);

    logic [CNT_W-1:0] count_reg;

    assign expired = (count_reg == CNT_W'(GAP_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Play/pause/skip sequencer driving song_reader; inserts a silent gap between
// auto-advanced songs and can loop back to the first song.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int NUM_SONGS  = NUM_SONGS_DEFAULT,
    parameter int GAP_CYCLES = 48000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_button,
    input  logic              next_button,
    input  logic              loop_en,
    input  logic              song_done,
    output logic              play,
    output logic [SONG_W-1:0] song,
    output logic              reset_player,
    output logic              in_gap
);

    seq_state_t        state_reg;
    seq_state_t        state_next;
    logic              resume_reg;
    logic              resume_next;
    logic [SONG_W-1:0] song_next;
    logic              gap_load;
    logic              gap_enable;
    logic              gap_expired;
    logic              last_song;

    assign last_song = (int'(song) == NUM_SONGS - 1);

    song_gap_timer #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_gap_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (gap_load),
        .enable (gap_enable),
        .expired(gap_expired)
    );

    // next_button outranks song_done, which outranks play_button.
    always_comb begin
        state_next  = state_reg;
        resume_next = resume_reg;
        song_next   = song;
        gap_load    = 1'b0;
        case (state_reg)
            CLEAR: begin
                state_next = resume_reg ? PLAYING : PAUSED;
            end
            PAUSED: begin
                if (next_button) begin
                    song_next   = advance_song(song, NUM_SONGS);
                    resume_next = 1'b0;
                    state_next  = CLEAR;
                end else if (play_button) begin
                    state_next = PLAYING;
                end
            end
            PLAYING: begin
                if (next_button) begin
                    song_next   = advance_song(song, NUM_SONGS);
                    resume_next = 1'b1;
                    state_next  = CLEAR;
                end else if (song_done) begin
                    if (!last_song || loop_en) begin
                        song_next  = advance_song(song, NUM_SONGS);
                        gap_load   = 1'b1;
                        state_next = GAP;
                    end else begin
                        song_next   = '0;
                        resume_next = 1'b0;
                        state_next  = CLEAR;
                    end
                end else if (play_button) begin
                    state_next = PAUSED;
                end
            end
            GAP: begin
                if (next_button) begin
                    song_next   = advance_song(song, NUM_SONGS);
                    resume_next = 1'b1;
                    state_next  = CLEAR;
                end else if (play_button) begin
                    resume_next = 1'b0;
                    state_next  = CLEAR;
                end else if (gap_expired) begin
                    resume_next = 1'b1;
                    state_next  = CLEAR;
                end
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
        gap_enable = (state_reg == GAP) && (state_next == GAP);
    end

    // Outputs are decoded from the next state so they land with the transition.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= CLEAR;
            resume_reg   <= 1'b0;
            song         <= '0;
            play         <= 1'b0;
            reset_player <= 1'b1;
            in_gap       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            resume_reg   <= resume_next;
            song         <= song_next;
            play         <= (state_next == PLAYING);
            reset_player <= (state_next == CLEAR);
            in_gap       <= (state_next == GAP);
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer (NUM_SONGS=4, GAP_CYCLES=4): a per-cycle
// behavioural model plus hand-computed expectations after each step.
module tb_song_sequencer;

    localparam int NS = 4;
    localparam int GC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       play_button = 1'b0;
    logic       next_button = 1'b0;
    logic       loop_en = 1'b0;
    logic       song_done = 1'b0;
    logic       play;
    logic [1:0] song;
    logic       reset_player;
    logic       in_gap;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    song_sequencer #(
        .NUM_SONGS (NS),
        .GAP_CYCLES(GC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .play_button (play_button),
        .next_button (next_button),
        .loop_en     (loop_en),
        .song_done   (song_done),
        .play        (play),
        .song        (song),
        .reset_player(reset_player),
        .in_gap      (in_gap)
    );

    always #5 clk = ~clk;

    // Model modes: clearing the player, idle, running, silent gap (counts down).
    localparam int M_CLR  = 0;
    localparam int M_IDLE = 1;
    localparam int M_RUN  = 2;
    localparam int M_GAP  = 3;

    typedef struct packed {
        int mode;
        bit resume;
        int song;
        int gap_left;
    } mstate_t;

    mstate_t m = '{mode: M_CLR, resume: 1'b0, song: 0, gap_left: 0};

    function automatic mstate_t model_step(input mstate_t s, input logic rst_n,
                                           input logic pb, input logic nb,
                                           input logic le, input logic sd);
        mstate_t r = s;
        if (!rst_n) begin
            r.mode = M_CLR; r.resume = 1'b0; r.song = 0; r.gap_left = 0;
            return r;
        end
        if (s.mode == M_CLR) begin
            r.mode = s.resume ? M_RUN : M_IDLE;
        end else if (s.mode == M_IDLE) begin
            if (nb) begin
                r.song = (s.song + 1) % NS; r.resume = 1'b0; r.mode = M_CLR;
            end else if (pb) begin
                r.mode = M_RUN;
            end
        end else if (s.mode == M_RUN) begin
            if (nb) begin
                r.song = (s.song + 1) % NS; r.resume = 1'b1; r.mode = M_CLR;
            end else if (sd) begin
                if (s.song < NS - 1 || le) begin
                    r.song = (s.song + 1) % NS; r.mode = M_GAP; r.gap_left = GC;
                end else begin
                    r.song = 0; r.resume = 1'b0; r.mode = M_CLR;
                end
            end else if (pb) begin
                r.mode = M_IDLE;
            end
        end else begin
            if (nb) begin
                r.song = (s.song + 1) % NS; r.resume = 1'b1; r.mode = M_CLR;
            end else if (pb) begin
                r.resume = 1'b0; r.mode = M_CLR;
            end else if (s.gap_left == 1) begin
                r.resume = 1'b1; r.mode = M_CLR;
            end else begin
                r.gap_left = s.gap_left - 1;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        m <= model_step(m, reset, play_button, next_button, loop_en, song_done);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("model_song", 32'(song), 32'(m.song));
                chk("model_play", 32'(play), 32'(m.mode == M_RUN));
                chk("model_reset_player", 32'(reset_player), 32'(m.mode == M_CLR));
                chk("model_in_gap", 32'(in_gap), 32'(m.mode == M_GAP));
            end
        end
    end

    task automatic expect4(input string tag, input int s, input int p, input int rp, input int g);
        chk({tag, "_song"}, 32'(song), 32'(s));
        chk({tag, "_play"}, 32'(play), 32'(p));
        chk({tag, "_reset_player"}, 32'(reset_player), 32'(rp));
        chk({tag, "_in_gap"}, 32'(in_gap), 32'(g));
    endtask

    // Entered 2 time units after a rising edge; returns 2 units after the next one.
    task automatic step(input logic pb, input logic nb, input logic sd);
        play_button = pb;
        next_button = nb;
        song_done   = sd;
        @(posedge clk);
        #2;
        play_button = 1'b0;
        next_button = 1'b0;
        song_done   = 1'b0;
        $display("t=%0t rst_n=%0b pb=%0b nb=%0b sd=%0b loop=%0b -> song=%0d play=%0b rp=%0b gap=%0b",
                 $time, reset, pb, nb, sd, loop_en, song, play, reset_player, in_gap);
    endtask

    initial begin
        @(posedge clk);
        #2;
        cmp_en = 1'b1;
        step(0, 0, 0);
        expect4("reset_hold", 0, 0, 1, 0);

        reset = 1'b1;
        step(0, 0, 0); expect4("post_reset_paused", 0, 0, 0, 0);
        step(1, 0, 0); expect4("first_play", 0, 1, 0, 0);
        step(0, 1, 0); expect4("skip_playing", 1, 0, 1, 0);
        step(0, 1, 0); expect4("next_in_clear_ignored", 1, 1, 0, 0);

        step(0, 0, 1); expect4("done_gap_enter", 2, 0, 0, 1);
        repeat (3) step(0, 0, 0);
        expect4("gap_cycle4", 2, 0, 0, 1);
        step(0, 0, 0); expect4("gap_to_clear", 2, 0, 1, 0);
        step(0, 0, 0); expect4("gap_resume", 2, 1, 0, 0);

        step(1, 1, 1); expect4("priority_next", 3, 0, 1, 0);
        step(0, 0, 0); expect4("priority_resume", 3, 1, 0, 0);

        loop_en = 1'b0;
        step(0, 0, 1); expect4("last_noloop_clear", 0, 0, 1, 0);
        step(0, 0, 0); expect4("last_noloop_paused", 0, 0, 0, 0);
        step(1, 0, 0); expect4("replay", 0, 1, 0, 0);

        step(1, 0, 0); expect4("pause_keeps_song", 0, 0, 0, 0);
        step(0, 0, 1); expect4("done_paused_ignored", 0, 0, 0, 0);
        step(0, 1, 0); expect4("skip_paused", 1, 0, 1, 0);
        step(0, 0, 0); expect4("skip_paused_stays", 1, 0, 0, 0);
        step(1, 0, 0); expect4("play_song1", 1, 1, 0, 0);

        step(0, 0, 1); expect4("gap_song2", 2, 0, 0, 1);
        step(1, 0, 0); expect4("gap_pause_clear", 2, 0, 1, 0);
        step(0, 0, 0); expect4("gap_pause_paused", 2, 0, 0, 0);
        step(1, 0, 0); expect4("play_song2", 2, 1, 0, 0);

        step(0, 0, 1); expect4("gap_song3", 3, 0, 0, 1);
        step(0, 1, 0); expect4("gap_skip_wraps", 0, 0, 1, 0);
        step(0, 0, 0); expect4("gap_skip_resume", 0, 1, 0, 0);

        repeat (3) begin
            step(0, 1, 0);
            step(0, 0, 0);
        end
        expect4("skip_to_last", 3, 1, 0, 0);

        loop_en = 1'b1;
        step(0, 0, 1); expect4("loop_wrap_gap", 0, 0, 0, 1);
        loop_en = 1'b0;
        repeat (3) step(0, 0, 0);
        step(0, 0, 0); expect4("loop_clear", 0, 0, 1, 0);
        step(0, 0, 0); expect4("loop_resume", 0, 1, 0, 0);

        step(0, 0, 1); expect4("gap_c1", 1, 0, 0, 1);
        step(0, 0, 0); expect4("gap_c2", 1, 0, 0, 1);
        reset = 1'b0;
        step(0, 0, 0); expect4("reset_mid_gap", 0, 0, 1, 0);
        reset = 1'b1;
        step(0, 0, 0); expect4("after_reset_paused", 0, 0, 0, 0);
        step(0, 0, 1); expect4("after_reset_done_ignored", 0, 0, 0, 0);

        step(0, 0, 0);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
